// File: rtl/set_bit_iterator_if.sv
// Handshake bundle for set_bit_iterator: mask load channel, index output channel, flush and zero-mask pulse.
interface set_bit_iterator_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             flush;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_mask;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic             out_last;
    logic             zero_mask;

    modport master (
        output flush, load_valid, load_mask, out_ready,
        input  load_ready, out_valid, out_index, out_last, zero_mask
    );

    modport slave (
        input  flush, load_valid, load_mask, out_ready,
        output load_ready, out_valid, out_index, out_last, zero_mask
    );
endinterface

// File: rtl/set_bit_iterator.sv
// Walks the set bits of a loaded mask, emitting one index per output handshake (MSB- or LSB-first).
// Optional macro SET_BIT_ITERATOR_COUNT_EN adds a `remaining` popcount output.
module set_bit_iterator #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    set_bit_iterator_if.slave   bus
`ifdef SET_BIT_ITERATOR_COUNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] remaining
`endif
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic {IDLE, ITER} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             zero_q, zero_d;

    logic [IDX_W-1:0] idx;
    logic             single;
    logic             active;
    logic             out_fire;
    logic             load_fire;

    // Priority pick: later loop iterations win, so loop direction sets the order.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending_q[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending_q[i]) idx = IDX_W'(i);
            end
        end
    end

    assign single    = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);
    assign active    = (state_q == ITER) && !rst;
    assign out_fire  = active && bus.out_ready;
    assign load_fire = bus.load_valid && bus.load_ready;

    assign bus.out_valid  = active;
    assign bus.out_index  = active ? idx : '0;
    assign bus.out_last   = active && single;
    assign bus.zero_mask  = zero_q && !rst;
    // Reload is allowed on the very edge that consumes the final bit, so there is no bubble.
    assign bus.load_ready = rst || (!bus.flush && ((state_q == IDLE) || (out_fire && single)));

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = 1'b0;
        if (bus.flush) begin
            state_d   = IDLE;
            pending_d = '0;
        end else if (load_fire) begin
            pending_d = bus.load_mask;
            state_d   = (bus.load_mask != '0) ? ITER : IDLE;
            zero_d    = (bus.load_mask == '0);
        end else if (out_fire) begin
            pending_d = pending_q & ~(WIDTH'(1) << idx);
            state_d   = (pending_d != '0) ? ITER : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

`ifdef SET_BIT_ITERATOR_COUNT_EN
    always_comb begin
        remaining = '0;
        for (int i = 0; i < WIDTH; i++) begin
            remaining = remaining + ($clog2(WIDTH+1))'(pending_q[i]);
        end
    end
`endif
endmodule

// File: tb/tb_set_bit_iterator.sv
// Random and directed stimulus for two set_bit_iterator instances (MSB-first and LSB-first) checked against queue models.
module tb_set_bit_iterator;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    set_bit_iterator_if #(.WIDTH(8)) bus_m ();
    set_bit_iterator_if #(.WIDTH(8)) bus_l ();

`ifdef SET_BIT_ITERATOR_COUNT_EN
    logic [3:0] rem_m, rem_l;
`endif

    set_bit_iterator #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
`ifdef SET_BIT_ITERATOR_COUNT_EN
        , .remaining (rem_m)
`endif
    );

    set_bit_iterator #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
`ifdef SET_BIT_ITERATOR_COUNT_EN
        , .remaining (rem_l)
`endif
    );

    int  n_vec  = 0;
    int  n_miss = 0;
    int  qm[$];
    int  ql[$];
    bit  zexp   = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected index order is simply the set bits listed high-to-low or low-to-high.
    function automatic void model_load(input logic [7:0] m);
        qm.delete();
        ql.delete();
        for (int i = 7; i >= 0; i--) if (m[i]) qm.push_back(i);
        for (int i = 0; i < 8; i++)  if (m[i]) ql.push_back(i);
    endfunction

    task automatic step(input bit r, input bit f, input bit lv, input logic [7:0] mk, input bit rdy);
        bit v, lrdy;
        rst              = r;
        bus_m.flush      = f;  bus_l.flush      = f;
        bus_m.load_valid = lv; bus_l.load_valid = lv;
        bus_m.load_mask  = mk; bus_l.load_mask  = mk;
        bus_m.out_ready  = rdy; bus_l.out_ready = rdy;
        @(negedge clk);
        v    = !r && (qm.size() > 0);
        lrdy = r || (!f && ((qm.size() == 0) || (rdy && qm.size() == 1)));
        chk("m_valid", int'(bus_m.out_valid), int'(v));
        chk("l_valid", int'(bus_l.out_valid), int'(v));
        chk("m_index", int'(bus_m.out_index), v ? qm[0] : 0);
        chk("l_index", int'(bus_l.out_index), v ? ql[0] : 0);
        chk("m_last",  int'(bus_m.out_last),  int'(v && qm.size() == 1));
        chk("l_last",  int'(bus_l.out_last),  int'(v && ql.size() == 1));
        chk("m_load_ready", int'(bus_m.load_ready), int'(lrdy));
        chk("l_load_ready", int'(bus_l.load_ready), int'(lrdy));
        chk("m_zero_mask",  int'(bus_m.zero_mask),  int'(!r && zexp));
        chk("l_zero_mask",  int'(bus_l.zero_mask),  int'(!r && zexp));
`ifdef SET_BIT_ITERATOR_COUNT_EN
        chk("m_remaining", int'(rem_m), r ? int'(rem_m) : qm.size());
        chk("l_remaining", int'(rem_l), r ? int'(rem_l) : ql.size());
`endif
        @(posedge clk);
        if (r || f) begin
            qm.delete();
            ql.delete();
            zexp = 1'b0;
        end else if (lv && lrdy) begin
            model_load(mk);
            zexp = (mk == 8'h00);
        end else begin
            zexp = 1'b0;
            if (qm.size() > 0 && rdy) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
        end
        #1;
    endtask

    initial begin
        bus_m.flush = 1'b0; bus_l.flush = 1'b0;
        bus_m.load_valid = 1'b0; bus_l.load_valid = 1'b0;
        bus_m.load_mask = 8'h00; bus_l.load_mask = 8'h00;
        bus_m.out_ready = 1'b0; bus_l.out_ready = 1'b0;

        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);

        // Mask 1010_0110 with continuous ready, then with ready toggling.
        step(0, 0, 1, 8'hA6, 1);
        repeat (5) step(0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 8'hA6, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 8'h00, (i % 2) == 0);

        // Zero mask pulse.
        step(0, 0, 1, 8'h00, 1);
        repeat (3) step(0, 0, 0, 8'h00, 1);

        // Back-to-back reload at the final handshake.
        step(0, 0, 1, 8'h81, 1);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 8'h10, 1);
        repeat (3) step(0, 0, 0, 8'h00, 1);

        // Flush then reset mid-iteration while a load is offered.
        step(0, 0, 1, 8'hFF, 1);
        repeat (2) step(0, 0, 0, 8'h00, 1);
        step(0, 1, 1, 8'h3C, 1);
        repeat (2) step(0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 8'hFF, 1);
        repeat (2) step(0, 0, 0, 8'h00, 1);
        step(1, 0, 1, 8'h3C, 1);
        repeat (2) step(0, 0, 0, 8'h00, 1);

        step(0, 0, 1, 8'hF0, 1);
        repeat (5) step(0, 0, 0, 8'h00, 1);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] mk;
            mk = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0,
                 mk,
                 $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
